// File: rtl/cmult_bank_sched.sv
// Round-robin arbiter and issue sequencer for the shared complex multiplier bank.
// Tracks each issued beat through the bank latency and routes the result valid back to its requester.
module cmult_bank_sched #(
    parameter int NREQ = 4,
    parameter int LAT  = 7,
    parameter int SELW = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req_valid,
    input  logic [NREQ-1:0] req_last,
    output logic [NREQ-1:0] req_ready,
    output logic [SELW-1:0] mux_sel,
    output logic            bank_issue,
    output logic [NREQ-1:0] rsp_valid,
    input  logic            flush_req,
    output logic            flush_done,
    output logic            busy
);

    // state | meaning
    // IDLE  | round-robin grant of single beats or burst starts
    // BURST | lane locked to owner until its last beat is accepted
    // DRAIN | no issue; wait for empty tag pipeline, then pulse flush_done
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BURST = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    localparam int IFW = $clog2(LAT + 1);

    logic [1:0]      state, state_nxt;
    logic [SELW-1:0] rr_ptr, rr_nxt;
    logic [SELW-1:0] owner, owner_nxt;
    logic            flush_pending, fp_nxt;

    logic [LAT-1:0]  tag_v;
    logic [SELW-1:0] tag_idx [LAT];
    logic [IFW-1:0]  in_flight;

    logic            gnt_found;
    logic [SELW-1:0] gnt_idx;
    logic [SELW-1:0] cand;

    logic [NREQ-1:0] rdy_c;
    logic [SELW-1:0] sel_c;
    logic            iss_c;
    logic            fd_c;

    function automatic logic [SELW-1:0] nxt_ptr(input logic [SELW-1:0] p);
        if (int'(p) == NREQ - 1)
            return '0;
        return p + 1'b1;
    endfunction

    // Descending scan so the candidate nearest rr_ptr is written last and wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = SELW'((int'(rr_ptr) + k) % NREQ);
            if (req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    always_comb begin
        rdy_c     = '0;
        sel_c     = '0;
        iss_c     = 1'b0;
        fd_c      = 1'b0;
        state_nxt = state;
        owner_nxt = owner;
        rr_nxt    = rr_ptr;
        fp_nxt    = flush_pending;
        case (state)
            IDLE: begin
                if (flush_req) begin
                    state_nxt = DRAIN;
                end else if (gnt_found) begin
                    rdy_c[gnt_idx] = 1'b1;
                    sel_c          = gnt_idx;
                    iss_c          = 1'b1;
                    if (req_last[gnt_idx]) begin
                        rr_nxt = nxt_ptr(gnt_idx);
                    end else begin
                        owner_nxt = gnt_idx;
                        state_nxt = BURST;
                    end
                end
            end
            BURST: begin
                rdy_c[owner] = 1'b1;
                sel_c        = owner;
                iss_c        = req_valid[owner];
                if (flush_req)
                    fp_nxt = 1'b1;
                if (req_valid[owner] && req_last[owner]) begin
                    state_nxt = (flush_pending || flush_req) ? DRAIN : IDLE;
                    rr_nxt    = nxt_ptr(owner);
                end
            end
            DRAIN: begin
                if (tag_v == '0) begin
                    fd_c      = 1'b1;
                    rr_nxt    = '0;
                    fp_nxt    = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Combinational outputs are forced low while reset is held so nothing issues during reset.
    assign req_ready  = rdy_c & {NREQ{reset}};
    assign mux_sel    = reset ? sel_c : '0;
    assign bank_issue = iss_c & reset;
    assign flush_done = fd_c & reset;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            owner         <= '0;
            flush_pending <= 1'b0;
        end else begin
            state         <= state_nxt;
            rr_ptr        <= rr_nxt;
            owner         <= owner_nxt;
            flush_pending <= fp_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag_v <= '0;
            for (int i = 0; i < LAT; i++)
                tag_idx[i] <= '0;
        end else begin
            tag_v[0]   <= bank_issue;
            tag_idx[0] <= mux_sel;
            for (int i = 1; i < LAT; i++) begin
                tag_v[i]   <= tag_v[i-1];
                tag_idx[i] <= tag_idx[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_flight <= '0;
        end else begin
            case ({bank_issue, tag_v[LAT-1]})
                2'b10:   in_flight <= in_flight + 1'b1;
                2'b01:   in_flight <= in_flight - 1'b1;
                default: in_flight <= in_flight;
            endcase
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (tag_v[LAT-1])
            rsp_valid[tag_idx[LAT-1]] = 1'b1;
    end

    assign busy = (in_flight != '0) || (state != IDLE);

endmodule

// File: tb/tb_cmult_bank_sched.sv
// Directed bench for cmult_bank_sched: a per-cycle vector table with hand-derived expectations,
// plus hand-written reset sequences.
module tb_cmult_bank_sched;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req_valid;
    logic [3:0] req_last;
    logic [3:0] req_ready;
    logic [1:0] mux_sel;
    logic       bank_issue;
    logic [3:0] rsp_valid;
    logic       flush_req;
    logic       flush_done;
    logic       busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0] v;
        logic [3:0] l;
        logic       f;
        logic [3:0] rdy;
        logic [1:0] sel;
        logic       iss;
        logic [3:0] rsp;
        logic       fd;
        logic       bsy;
    } vec_t;

    vec_t vecs[$];

    cmult_bank_sched #(.NREQ(4), .LAT(7)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .mux_sel    (mux_sel),
        .bank_issue (bank_issue),
        .rsp_valid  (rsp_valid),
        .flush_req  (flush_req),
        .flush_done (flush_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] rdy, input logic [1:0] sel,
                           input logic iss, input logic [3:0] rsp, input logic fd, input logic bsy);
        chk({tag, " ready"},  int'(req_ready),  int'(rdy));
        chk({tag, " sel"},    int'(mux_sel),    int'(sel));
        chk({tag, " issue"},  int'(bank_issue), int'(iss));
        chk({tag, " rsp"},    int'(rsp_valid),  int'(rsp));
        chk({tag, " fdone"},  int'(flush_done), int'(fd));
        chk({tag, " busy"},   int'(busy),       int'(bsy));
    endtask

    task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic f);
        @(posedge clk);
        #1;
        req_valid = v;
        req_last  = l;
        flush_req = f;
        #2;
    endtask

    function automatic void add(input logic [3:0] v, input logic [3:0] l, input logic f,
                                input logic [3:0] rdy, input logic [1:0] sel, input logic iss,
                                input logic [3:0] rsp, input logic fd, input logic bsy);
        vec_t e;
        e.v = v; e.l = l; e.f = f; e.rdy = rdy; e.sel = sel;
        e.iss = iss; e.rsp = rsp; e.fd = fd; e.bsy = bsy;
        vecs.push_back(e);
    endfunction

    initial begin
        // Round robin, single-beat bursts from all four, rr_ptr=0; responses 7 cycles later.
        for (int t = 0; t < 18; t++)
            add((t < 10) ? 4'hF : 4'h0, (t < 10) ? 4'hF : 4'h0, 1'b0,
                (t < 10) ? (4'b0001 << (t % 4)) : 4'h0, (t < 10) ? 2'(t % 4) : 2'd0, t < 10,
                (t >= 7 && t <= 16) ? (4'b0001 << ((t - 7) % 4)) : 4'h0, 1'b0, (t >= 1 && t <= 16));
        // Burst lock: requester 2 five beats while 0 and 3 wait; then 3, then 0.
        for (int u = 0; u < 5; u++)
            add(4'b1101, (u == 4) ? 4'b1101 : 4'b1001, 1'b0, 4'b0100, 2'd2, 1'b1, 4'h0, 1'b0, u >= 1);
        add(4'b1001, 4'b1001, 1'b0, 4'b1000, 2'd3, 1'b1, 4'h0, 1'b0, 1'b1);
        add(4'b0001, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 4'h0, 1'b0, 1'b1);
        for (int u = 7; u < 15; u++)
            add(4'h0, 4'h0, 1'b0, 4'h0, 2'd0, 1'b0,
                (u <= 11) ? 4'b0100 : (u == 12) ? 4'b1000 : (u == 13) ? 4'b0001 : 4'h0,
                1'b0, u <= 13);
        // Burst gap: requester 1 drops valid for 3 cycles mid-burst.
        add(4'b1111, 4'b1101, 1'b0, 4'b0010, 2'd1, 1'b1, 4'h0, 1'b0, 1'b0);
        add(4'b1111, 4'b1101, 1'b0, 4'b0010, 2'd1, 1'b1, 4'h0, 1'b0, 1'b1);
        for (int w = 2; w < 5; w++)
            add(4'b1101, 4'b1101, 1'b0, 4'b0010, 2'd1, 1'b0, 4'h0, 1'b0, 1'b1);
        add(4'b1111, 4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1, 4'h0, 1'b0, 1'b1);
        for (int w = 6; w < 14; w++)
            add(4'h0, 4'h0, 1'b0, 4'h0, 2'd0, 1'b0,
                (w == 7 || w == 8 || w == 12) ? 4'b0010 : 4'h0, 1'b0, w <= 12);
        // Flush pulse on beat 2 of a 4-beat burst from requester 0.
        add(4'b0001, 4'b0000, 1'b0, 4'b0001, 2'd0, 1'b1, 4'h0, 1'b0, 1'b0);
        add(4'b0001, 4'b0000, 1'b1, 4'b0001, 2'd0, 1'b1, 4'h0, 1'b0, 1'b1);
        add(4'b0001, 4'b0000, 1'b0, 4'b0001, 2'd0, 1'b1, 4'h0, 1'b0, 1'b1);
        add(4'b0001, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 4'h0, 1'b0, 1'b1);
        for (int k = 4; k < 12; k++)
            add(4'b0001, 4'b0001, 1'b0, 4'h0, 2'd0, 1'b0,
                (k >= 7 && k <= 10) ? 4'b0001 : 4'h0, k == 11, 1'b1);
        add(4'b1111, 4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 4'h0, 1'b0, 1'b0);
        for (int k = 13; k < 21; k++)
            add(4'h0, 4'h0, 1'b0, 4'h0, 2'd0, 1'b0, (k == 19) ? 4'b0001 : 4'h0, 1'b0, k <= 19);
        // Idle flush, then flush held high across two drain cycles (with a blocked request).
        add(4'h0,    4'h0,    1'b1, 4'h0, 2'd0, 1'b0, 4'h0, 1'b0, 1'b0);
        add(4'h0,    4'h0,    1'b0, 4'h0, 2'd0, 1'b0, 4'h0, 1'b1, 1'b1);
        add(4'h0,    4'h0,    1'b0, 4'h0, 2'd0, 1'b0, 4'h0, 1'b0, 1'b0);
        add(4'b0001, 4'b0001, 1'b1, 4'h0, 2'd0, 1'b0, 4'h0, 1'b0, 1'b0);
        add(4'h0,    4'h0,    1'b1, 4'h0, 2'd0, 1'b0, 4'h0, 1'b1, 1'b1);
        add(4'h0,    4'h0,    1'b1, 4'h0, 2'd0, 1'b0, 4'h0, 1'b0, 1'b0);
        add(4'h0,    4'h0,    1'b0, 4'h0, 2'd0, 1'b0, 4'h0, 1'b1, 1'b1);
        add(4'h0,    4'h0,    1'b0, 4'h0, 2'd0, 1'b0, 4'h0, 1'b0, 1'b0);

        // Reset held with requests present: all outputs must stay low.
        reset     = 1'b0;
        req_valid = 4'hF;
        req_last  = 4'hF;
        flush_req = 1'b0;
        #12;
        chk_all("reset", 4'h0, 2'd0, 1'b0, 4'h0, 1'b0, 1'b0);
        req_valid = 4'h0;
        req_last  = 4'h0;
        @(posedge clk);
        #1;
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].v, vecs[i].l, vecs[i].f);
            chk_all($sformatf("vec%0d", i), vecs[i].rdy, vecs[i].sel, vecs[i].iss,
                    vecs[i].rsp, vecs[i].fd, vecs[i].bsy);
        end

        // Reset mid-flight: three beats issued (rr_ptr=0 after the flushes), then a 1-cycle reset.
        for (int d = 0; d < 3; d++) begin
            drive(4'hF, 4'hF, 1'b0);
            chk_all($sformatf("mid%0d", d), 4'b0001 << d, 2'(d), 1'b1, 4'h0, 1'b0, d != 0);
        end
        @(posedge clk);
        #1;
        reset     = 1'b0;
        req_valid = 4'hF;
        #2;
        chk_all("rst_low", 4'h0, 2'd0, 1'b0, 4'h0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        reset     = 1'b1;
        req_valid = 4'h0;
        req_last  = 4'h0;
        #2;
        chk_all("rst_rel", 4'h0, 2'd0, 1'b0, 4'h0, 1'b0, 1'b0);
        for (int e = 0; e < 10; e++) begin
            drive(4'h0, 4'h0, 1'b0);
            chk_all($sformatf("post%0d", e), 4'h0, 2'd0, 1'b0, 4'h0, 1'b0, 1'b0);
        end
        // rr_ptr is back at 0, so the scan from 0 finds requester 3 first.
        drive(4'b1000, 4'b1000, 1'b0);
        chk_all("post_gnt", 4'b1000, 2'd3, 1'b1, 4'h0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cmult_bank_sched.md
# cmult_bank_sched

Arbiter and sequencer that time-shares the 16-lane FP complex multiplier bank between NREQ requesters (FFT stages, filter engines). It grants bank access in round-robin order with burst locking, drives the operand-mux select and issue strobe, and tracks each issued beat through the fixed-latency multiplier pipeline. When results emerge from the bank, it routes the valid to the originating requester. It also supports a drain command that stops new issue and signals once the pipeline is empty.

## Interface
Parameters:
- NREQ, default 4: number of requesters; legal range 2..8.
- LAT, default 7: multiplier bank latency in cycles from operand presentation to q/r valid; minimum 1.
- SELW, default $clog2(NREQ): width of the mux select.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  requester i has an operand beat on its lane set.
- req_last  in  NREQ  marks the final beat of requester i's burst; qualified by req_valid[i].
- req_ready  out  NREQ  beat of requester i is accepted this cycle when req_valid[i] is also 1.
- mux_sel  out  SELW  index of the requester whose a/b/c/d operands drive the bank this cycle.
- bank_issue  out  1  operands at the bank input are a real beat this cycle.
- rsp_valid  out  NREQ  one-hot; q/r from the bank belong to requester i this cycle.
- flush_req  in  1  request to drain; level-sampled.
- flush_done  out  1  one-cycle pulse when the drain completes.
- busy  out  1  asserted when any beat is in flight or state is not IDLE.

## Operation
States are IDLE, BURST and DRAIN.

IDLE:
- If flush_req=1: no grant; next state DRAIN. Flush has priority over a new grant.
- Otherwise, the grant g is the first index at or after rr_ptr, with wrap, whose req_valid=1. This is combinational the same cycle.
- req_ready[g]=1, mux_sel=g, bank_issue=1 (beat accepted).
- If the accepted beat has req_last[g]=1: stay IDLE, rr_ptr <= (g+1) mod NREQ.
- Otherwise: owner <= g, next state BURST.
- With no request: all outputs are 0 and mux_sel holds 0.

BURST:
- req_ready[owner]=1, all other ready bits 0, mux_sel=owner.
- bank_issue = req_valid[owner]. Gaps inside a burst are allowed and do not release the lock.
- When a beat is accepted with req_last[owner]=1:
  - next state is DRAIN if flush is pending, else IDLE;
  - rr_ptr <= (owner+1) mod NREQ.
- flush_req=1 during BURST sets flush_pending. The burst is never truncated.

DRAIN:
- All req_ready are 0 and bank_issue=0.
- When the tag pipeline holds no valid entry: flush_done=1 for one cycle, rr_ptr <= 0, clear flush_pending, next state IDLE.

Tag pipeline:
- LAT stages of {valid, idx}. Stage 0 loads {bank_issue, mux_sel} every cycle.
- rsp_valid = onehot(idx of last stage) gated by its valid bit.
- in_flight counter, width $clog2(LAT+1):
  - increments on issue and decrements on last-stage valid;
  - both in the same cycle means no change;
  - never exceeds LAT.
- busy = (in_flight != 0) || (state != IDLE).

## Timing
- Reset (reset=0, asynchronous):
  - state IDLE, rr_ptr 0, owner 0, flush_pending 0;
  - all tag stages invalid, in_flight 0;
  - all outputs 0.
  - In-flight results are discarded: no rsp_valid follows a mid-operation reset.
  - Release is synchronous to clk, first grant possible in the first cycle after release.
- Grant latency is 0 cycles. Ready is combinational from req_valid and registered state.
- A beat issued in cycle t produces rsp_valid in cycle t+LAT, aligned with the bank's q/r.
- There is no backpressure on responses. Requesters must accept rsp_valid unconditionally.
- Back-to-back bursts from different requesters have zero bubble cycles. Single-beat bursts (req_last on the first beat) rotate every cycle.
- flush_done occurs no earlier than the cycle after the last rsp_valid. If DRAIN is entered with an empty pipeline, flush_done fires in the first DRAIN cycle.
- flush_req held high continuously produces repeated DRAIN/flush_done cycles. Each return to IDLE re-samples it.

## Test plan
- Round-robin with all four requesting single-beat bursts continuously, rr_ptr=0:
  - grants are 0,1,2,3,0,... on consecutive cycles;
  - rsp_valid onehot repeats the same order starting LAT=7 cycles later.
- Burst lock:
  - requester 2 sends 5 beats (last on beat 5) while 0 and 3 also request;
  - only ready[2] is asserted for 5 accepted beats; the next grant is 3, then 0.
- Burst gap: requester 1 deasserts valid for 3 cycles mid-burst -> no other requester is granted, bank_issue=0 during the gap.
- Flush during burst:
  - flush_req pulses while requester 0 is on beat 2 of 4;
  - beats 3 and 4 still issue;
  - DRAIN is entered, flush_done pulses one cycle after the final rsp_valid (issue cycle +LAT+1), then rr_ptr=0.
- Reset mid-flight:
  - 3 beats are in flight and reset is pulled low for 1 cycle;
  - all outputs drop to 0 immediately, no rsp_valid appears afterwards, busy=0.
- Idle flush: flush_req=1 with no traffic -> flush_done in the cycle DRAIN is entered, busy=1 for exactly that cycle.
